height_history: RTL and testbench

- Sequential producer for the 10-entry height history consumed by the combinational sorter.
- Accepts one validated height reading (inches) per strobe and shifts it into a 10-deep history, newest at index 0.
- Range-checks each reading, tracks fill level, and strobes downstream when the history changes.
- Sits between the sensor-to-inches conversion stage and the sorter.

---
 rtl/height_pkg.sv | 9 +
 rtl/height_range_check.sv | 12 +
 rtl/height_history.sv | 83 ++++++++
 tb/tb_height_history.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/height_pkg.sv
// height_pkg: shared widths, depth, height type and history state enum
package height_pkg;
  localparam int HEIGHT_W = 8;
  localparam int HIST_DEPTH = 10;
  typedef logic [HEIGHT_W-1:0] height_t;
  localparam height_t DEF_MIN_IN = 8'd12;
  localparam height_t DEF_MAX_IN = 8'd96;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} hist_state_t;
endpackage

// File: rtl/height_range_check.sv
// height_range_check: flags a reading lying inside [MIN_IN, MAX_IN]
module height_range_check
  import height_pkg::*;
#(
  parameter height_t MIN_IN = DEF_MIN_IN,
  parameter height_t MAX_IN = DEF_MAX_IN
) (
  input  height_t sample,
  output logic    in_range
);
  assign in_range = (sample >= MIN_IN) && (sample <= MAX_IN);
endmodule

// File: rtl/height_history.sv
// height_history: 10-deep shifting history of range-checked height readings
module height_history
  import height_pkg::*;
#(
  parameter height_t MIN_IN = DEF_MIN_IN,
  parameter height_t MAX_IN = DEF_MAX_IN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic [7:0] sample_in,
  output logic [7:0] hist_0,
  output logic [7:0] hist_1,
  output logic [7:0] hist_2,
  output logic [7:0] hist_3,
  output logic [7:0] hist_4,
  output logic [7:0] hist_5,
  output logic [7:0] hist_6,
  output logic [7:0] hist_7,
  output logic [7:0] hist_8,
  output logic [7:0] hist_9,
  output logic [3:0] count,
  output logic       full,
  output logic       updated,
  output logic       reject,
  output logic [7:0] reject_cnt
);
  localparam int DEPTH = HIST_DEPTH;
  height_t hist [DEPTH];
  hist_state_t state, state_next;
  logic in_range, accept, bad;
  height_range_check #(.MIN_IN(MIN_IN), .MAX_IN(MAX_IN)) u_range (
    .sample  (sample_in),
    .in_range(in_range)
  );
  assign accept = sample_valid && in_range && !clear;
  assign bad = sample_valid && !in_range && !clear;
  // next state: clear flushes, the accept reaching DEPTH entries (or any accept once full) lands in FULL
  always_comb begin
    state_next = clear ? EMPTY
               : !accept ? state
               : (state == FULL || count == 4'(DEPTH - 1)) ? FULL : FILLING;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else state <= state_next;
  end
  // history shift register, newest at index 0, oldest falls off the end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) hist <= '{default: '0};
    else if (accept) begin
      for (int k = DEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= sample_in;
    end
  end
  // fill level, change/reject pulses and saturating reject counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      updated <= 1'b0;
      reject <= 1'b0;
      reject_cnt <= '0;
    end else begin
      count <= clear ? 4'd0 : (accept && count != 4'(DEPTH)) ? count + 4'd1 : count;
      updated <= clear ? (count != 4'd0) : accept;
      reject <= bad;
      reject_cnt <= clear ? 8'd0 : (bad && reject_cnt != 8'hff) ? reject_cnt + 8'd1 : reject_cnt;
    end
  end
  assign full = (state == FULL);
  assign hist_0 = hist[0];
  assign hist_1 = hist[1];
  assign hist_2 = hist[2];
  assign hist_3 = hist[3];
  assign hist_4 = hist[4];
  assign hist_5 = hist[5];
  assign hist_6 = hist[6];
  assign hist_7 = hist[7];
  assign hist_8 = hist[8];
  assign hist_9 = hist[9];
endmodule

// File: tb/tb_height_history.sv
// tb_height_history: directed and random checks of height_history against a queue model
module tb_height_history;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, sample_valid = 1'b0;
  logic [7:0] sample_in = '0;
  logic [7:0] hist_0, hist_1, hist_2, hist_3, hist_4, hist_5, hist_6, hist_7, hist_8, hist_9;
  logic [3:0] count;
  logic full, updated, reject;
  logic [7:0] reject_cnt;
  logic [7:0] h [10];
  int q[$];
  int exp_upd = 0, exp_rej = 0, exp_rcnt = 0;
  int n_assert = 0, n_fail = 0;

  height_history dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_valid(sample_valid), .sample_in(sample_in),
    .hist_0(hist_0), .hist_1(hist_1), .hist_2(hist_2), .hist_3(hist_3), .hist_4(hist_4),
    .hist_5(hist_5), .hist_6(hist_6), .hist_7(hist_7), .hist_8(hist_8), .hist_9(hist_9),
    .count(count), .full(full), .updated(updated), .reject(reject), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  assign h[0] = hist_0;
  assign h[1] = hist_1;
  assign h[2] = hist_2;
  assign h[3] = hist_3;
  assign h[4] = hist_4;
  assign h[5] = hist_5;
  assign h[6] = hist_6;
  assign h[7] = hist_7;
  assign h[8] = hist_8;
  assign h[9] = hist_9;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 10; k++)
      chk($sformatf("hist_%0d", k), 32'(h[k]), (k < q.size()) ? q[k] : 0);
    chk("count", 32'(count), q.size());
    chk("full", 32'(full), 32'(q.size() == 10));
    chk("updated", 32'(updated), exp_upd);
    chk("reject", 32'(reject), exp_rej);
    chk("reject_cnt", 32'(reject_cnt), exp_rcnt);
  endtask

  task automatic model_reset();
    q.delete();
    exp_upd = 0;
    exp_rej = 0;
    exp_rcnt = 0;
  endtask

  task automatic tick(input logic v, input logic [7:0] s, input logic c);
    sample_valid = v;
    sample_in = s;
    clear = c;
    @(posedge clk);
    if (c) begin
      exp_upd = (q.size() != 0);
      exp_rej = 0;
      exp_rcnt = 0;
      q.delete();
    end else if (v && s >= 12 && s <= 96) begin
      q.push_front(int'(s));
      if (q.size() > 10) void'(q.pop_back());
      exp_upd = 1;
      exp_rej = 0;
    end else begin
      exp_upd = 0;
      exp_rej = v;
      if (v && exp_rcnt < 255) exp_rcnt++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    clear = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
    tick(0, 8'd0, 1);
    foreach (q[i]) chk("dummy_never", 0, 0);
    tick(1, 8'd60, 0);
    tick(1, 8'd62, 0);
    tick(1, 8'd58, 0);
    chk("tp2_h0", 32'(hist_0), 58);
    chk("tp2_h1", 32'(hist_1), 62);
    chk("tp2_h2", 32'(hist_2), 60);
    chk("tp2_count", 32'(count), 3);
    tick(1, 8'd0, 1);
    for (int i = 50; i <= 61; i++) tick(1, 8'(i), 0);
    chk("tp3_h0", 32'(hist_0), 61);
    chk("tp3_h9", 32'(hist_9), 52);
    chk("tp3_full", 32'(full), 1);
    tick(0, 8'd0, 1);
    tick(1, 8'd11, 0);
    tick(1, 8'd97, 0);
    tick(1, 8'd12, 0);
    tick(1, 8'd96, 0);
    chk("tp4_rcnt", 32'(reject_cnt), 2);
    chk("tp4_h0", 32'(hist_0), 96);
    chk("tp4_h1", 32'(hist_1), 12);
    chk("tp4_count", 32'(count), 2);
    tick(0, 8'd0, 1);
    for (int i = 0; i < 4; i++) tick(1, 8'(20 + i), 0);
    tick(1, 8'd70, 1);
    chk("tp5_updated", 32'(updated), 1);
    chk("tp5_reject", 32'(reject), 0);
    chk("tp5_h0", 32'(hist_0), 0);
    tick(0, 8'd0, 1);
    chk("clear_empty_updated", 32'(updated), 0);
    for (int i = 0; i < 3; i++) tick(1, 8'(30 + i), 0);
    for (int i = 0; i < 300; i++)
      tick(1, $urandom_range(0, 1) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(97, 255)), 0);
    chk("tp6_rcnt", 32'(reject_cnt), 255);
    chk("tp6_count", 32'(count), 3);
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 3) != 0,
           $urandom_range(0, 1) ? 8'($urandom_range(12, 96)) : 8'($urandom_range(0, 255)),
           $urandom_range(0, 19) == 0);
    tick(0, 8'd0, 1);
    for (int i = 0; i < 5; i++) tick(1, 8'(40 + i), 0);
    tick(1, 8'd11, 0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    tick(1, 8'd45, 0);
    chk("post_reset_count", 32'(count), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
